// File: rtl/tcu_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler and its job source, operand
// stream, tensor core control and result consumer.
// KW must match the KW parameter of the tcu_tile_scheduler it connects to.
interface tcu_tile_scheduler_if #(
  parameter int KW = 8
);
  logic          req_valid;
  logic [KW-1:0] req_ktiles;
  logic          req_ready;
  logic          tile_valid;
  logic          tile_ready;
  logic          core_load;
  logic          c_sel;
  logic          w_capture;
  logic          resp_valid;
  logic          resp_ready;
  logic          flush;
  logic          busy;

  // Scheduler side
  modport slave (
    input  req_valid, req_ktiles, tile_valid, resp_ready, flush,
    output req_ready, tile_ready, core_load, c_sel, w_capture, resp_valid, busy
  );

  // Job source / datapath side
  modport master (
    output req_valid, req_ktiles, tile_valid, resp_ready, flush,
    input  req_ready, tile_ready, core_load, c_sel, w_capture, resp_valid, busy
  );
endinterface

// File: rtl/tcu_tile_scheduler.sv
// Tile scheduler for a 4x4 sub-tensor core: accepts a job of k tiles, fetches
// each A/B tile, fires the core, waits LATENCY cycles (2..255) for W, and
// accumulates by feeding W back as C for every tile after the first.
// Optional feature: define TCU_SCHED_PERF_CNT_EN to add the 32-bit saturating
// perf_busy_cycles output counting cycles with busy high.
module tcu_tile_scheduler #(
  parameter int LATENCY = 11,
  parameter int KW      = 8
) (
  input logic                 clk,
  input logic                 rst,
  tcu_tile_scheduler_if.slave bus
`ifdef TCU_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]         perf_busy_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [7:0]    WAIT_LOAD = 8'(LATENCY - 1);
  localparam logic [KW-1:0] K_ONE     = KW'(1);

  state_t        r_state;
  logic [7:0]    r_waitCnt;
  logic [KW-1:0] r_kLeft;
  logic          r_reqReady;
  logic          r_tileReady;
  logic          r_coreLoad;
  logic          r_cSel;
  logic          r_wCapture;
  logic          r_respValid;
  logic          r_busy;

  logic [KW-1:0] w_reqKtiles;

  // A zero-length job still runs one tile
  assign w_reqKtiles = (bus.req_ktiles == '0) ? K_ONE : bus.req_ktiles;

  // Scheduler FSM; every output is a register loaded alongside the state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_waitCnt   <= '0;
      r_kLeft     <= '0;
      r_reqReady  <= 1'b1;
      r_tileReady <= 1'b0;
      r_coreLoad  <= 1'b0;
      r_cSel      <= 1'b0;
      r_wCapture  <= 1'b0;
      r_respValid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_waitCnt   <= '0;
      r_kLeft     <= '0;
      r_reqReady  <= 1'b1;
      r_tileReady <= 1'b0;
      r_coreLoad  <= 1'b0;
      r_cSel      <= 1'b0;
      r_wCapture  <= 1'b0;
      r_respValid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_kLeft     <= w_reqKtiles;
            r_cSel      <= 1'b0;
            r_reqReady  <= 1'b0;
            r_tileReady <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.tile_valid) begin
            r_tileReady <= 1'b0;
            r_coreLoad  <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_coreLoad <= 1'b0;
          r_waitCnt  <= WAIT_LOAD;
          r_wCapture <= 1'b0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_waitCnt == 8'd0) begin
            r_wCapture <= 1'b0;
            r_kLeft    <= r_kLeft - K_ONE;
            if (r_kLeft > K_ONE) begin
              r_cSel      <= 1'b1;
              r_tileReady <= 1'b1;
              r_state     <= S_FETCH;
            end else begin
              r_respValid <= 1'b1;
              r_state     <= S_RESP;
            end
          end else begin
            r_waitCnt  <= r_waitCnt - 8'd1;
            r_wCapture <= (r_waitCnt == 8'd1);
          end
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            r_respValid <= 1'b0;
            r_reqReady  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_reqReady  <= 1'b1;
          r_tileReady <= 1'b0;
          r_coreLoad  <= 1'b0;
          r_wCapture  <= 1'b0;
          r_respValid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // A flush cycle must not hand out any handshake or strobe, so mask them with it
  assign bus.req_ready  = r_reqReady  & ~bus.flush;
  assign bus.tile_ready = r_tileReady & ~bus.flush;
  assign bus.core_load  = r_coreLoad  & ~bus.flush;
  assign bus.w_capture  = r_wCapture  & ~bus.flush;
  assign bus.resp_valid = r_respValid & ~bus.flush;
  assign bus.c_sel      = r_cSel;
  assign bus.busy       = r_busy;

`ifdef TCU_SCHED_PERF_CNT_EN
  logic [31:0] r_perfBusy;

  // Busy-cycle counter that sticks at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perfBusy <= '0;
    end else if (r_busy && (r_perfBusy != 32'hFFFF_FFFF)) begin
      r_perfBusy <= r_perfBusy + 32'd1;
    end
  end

  assign perf_busy_cycles = r_perfBusy;
`endif

endmodule

// File: tb/tb_tcu_tile_scheduler.sv
// Self-checking bench for tcu_tile_scheduler: each job pushes its expected
// core_load / w_capture / response-handshake events with absolute cycle
// numbers onto a queue, and a monitor pops them as the DUT produces them.
module tb_tcu_tile_scheduler;

  localparam int LAT = 11;

  localparam int EV_LOAD = 0;
  localparam int EV_CAP  = 1;
  localparam int EV_RESP = 2;

  typedef struct {
    int   kind;
    int   cyc;
    logic csel;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic respPending = 1'b0;
  ev_t  expQ[$];

  tcu_tile_scheduler_if #(.KW(8)) bus();

`ifdef TCU_SCHED_PERF_CNT_EN
  logic [31:0] perf_busy_cycles;
`endif

  tcu_tile_scheduler #(
    .LATENCY(LAT),
    .KW(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef TCU_SCHED_PERF_CNT_EN
    ,
    .perf_busy_cycles(perf_busy_cycles)
`endif
  );

  // 10-time-unit clock
  always #5 clk = ~clk;

  // Absolute cycle index; cycle n lies between rising edges n and n+1
  always @(posedge clk) cyc <= cyc + 1;

  // Single comparison point: counts every check and reports a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input int when, input logic csel);
    ev_t e;
    e.kind = kind;
    e.cyc  = when;
    e.csel = csel;
    expQ.push_back(e);
  endtask

  task automatic popEv(input int kind, input logic csel);
    ev_t e;
    if (expQ.size() == 0) begin
      checkOutput("unexpected_event", kind + 1, 0);
    end else begin
      e = expQ.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_cycle", cyc, e.cyc);
      if (kind == EV_LOAD) checkOutput("c_sel_at_load", csel, e.csel);
    end
  endtask

  // Monitor: samples 2 units after the falling edge, after the drivers settle
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        respPending = 1'b0;
      end else begin
        checkOutput("strobe_excl",
                    ((int'(bus.req_ready) + int'(bus.tile_ready) + int'(bus.core_load) + int'(bus.w_capture)) <= 1),
                    1);
        if (respPending && !bus.flush) checkOutput("resp_hold", bus.resp_valid, 1);
        respPending = bus.resp_valid && !bus.resp_ready;
        if (bus.core_load) popEv(EV_LOAD, bus.c_sel);
        if (bus.w_capture) popEv(EV_CAP, 1'b0);
        if (bus.resp_valid && bus.resp_ready) popEv(EV_RESP, 1'b0);
      end
    end
  end

  // One job: k tiles, tile_valid low for d FETCH cycles on the first tile,
  // resp_ready low for r RESP cycles, optional flush in WAIT of tile flushTile
  task automatic applyStimulus(input int k, input int d, input int r, input int flushTile);
    int a, kEff, load, cap, fc, respStart, endCyc;
    @(negedge clk);
    a = cyc;
    checkOutput("idle_req_ready", bus.req_ready, 1);
    kEff      = (k == 0) ? 1 : k;
    load      = a + 2 + d;
    cap       = 0;
    fc        = -1;
    respStart = 0;
    for (int i = 0; i < kEff; i++) begin
      pushEv(EV_LOAD, load, (i > 0));
      if (flushTile == i + 1) begin
        fc = load + 3;
        break;
      end
      cap = load + LAT;
      pushEv(EV_CAP, cap, 1'b0);
      load = cap + 2;
    end
    if (fc < 0) begin
      respStart = cap + 1;
      pushEv(EV_RESP, respStart + r, 1'b0);
      endCyc = respStart + r + 1;
    end else begin
      respStart = 1 << 30;
      endCyc = fc + LAT + 2;
    end
    for (int c = a; c <= endCyc; c++) begin
      if (c != a) @(negedge clk);
      bus.req_valid  = (c == a);
      bus.req_ktiles = 8'(k);
      bus.tile_valid = (c - a > d);
      bus.resp_ready = (r == 0) || (c >= respStart + r);
      bus.flush      = (c == fc);
      if (c == fc + 1) begin
        #2;
        checkOutput("flush_busy", bus.busy, 0);
        checkOutput("flush_req_ready", bus.req_ready, 1);
        checkOutput("flush_resp_valid", bus.resp_valid, 0);
      end
    end
    #2;
    checkOutput("end_busy", bus.busy, 0);
    checkOutput("end_req_ready", bus.req_ready, 1);
    checkOutput("end_resp_valid", bus.resp_valid, 0);
    checkOutput("end_pending", expQ.size(), 0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Test sequence
  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_ktiles = 8'd0;
    bus.tile_valid = 1'b0;
    bus.resp_ready = 1'b0;
    bus.flush      = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_core_load", bus.core_load, 0);
    checkOutput("rst_w_capture", bus.w_capture, 0);
    checkOutput("rst_tile_ready", bus.tile_ready, 0);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_c_sel", bus.c_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    checkOutput("post_rst_req_ready", bus.req_ready, 1);

    $display("[TB] single tile job");
    applyStimulus(1, 0, 0, 0);
`ifdef TCU_SCHED_PERF_CNT_EN
    checkOutput("perf_busy_cycles", perf_busy_cycles, 14);
`endif

    $display("[TB] four tile job");
    applyStimulus(4, 0, 0, 0);

    $display("[TB] zero ktiles job");
    applyStimulus(0, 0, 0, 0);

    $display("[TB] stalled tile and response");
    applyStimulus(1, 5, 7, 0);

    $display("[TB] flush during tile 2 of 3");
    applyStimulus(3, 0, 0, 2);

    $display("[TB] request together with flush");
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_ktiles = 8'd1;
    bus.tile_valid = 1'b1;
    bus.resp_ready = 1'b1;
    bus.flush      = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    #2;
    checkOutput("flush_req_busy", bus.busy, 0);
    checkOutput("flush_req_ready", bus.req_ready, 1);

    $display("[TB] two tile job after flush");
    applyStimulus(2, 0, 3, 0);

    repeat (3) @(negedge clk);
    checkOutput("final_pending", expQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tcu_tile_scheduler.md
TCU_TILE_SCHEDULER -- requirements
Module: tcu_tile_scheduler

Interface
REQ-001 SHALL have parameter LATENCY, default 11: cycles from core_load to a valid core W output (range 2..255).
REQ-002 SHALL have parameter KW, default 8: width of the k-tile count field.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, a job request is present.
REQ-006 SHALL have port req_ktiles, input, KW, number of 4x4 k-tiles to accumulate (0 treated as 1).
REQ-007 SHALL have port req_ready, output, 1, job accepted when high together with req_valid.
REQ-008 SHALL have port tile_valid, input, 1, upstream A/B tile operands are ready at the core inputs.
REQ-009 SHALL have port tile_ready, output, 1, tile consumed when high together with tile_valid.
REQ-010 SHALL have port core_load, output, 1, one-cycle strobe latching A/B/C into the sub_tensor_core operand registers.
REQ-011 SHALL have port c_sel, output, 1, C-operand mux: 0 = external C, 1 = fed-back W.
REQ-012 SHALL have port w_capture, output, 1, one-cycle strobe capturing core W outputs into the result register.
REQ-013 SHALL have port resp_valid, output, 1, accumulated result is held and valid.
REQ-014 SHALL have port resp_ready, input, 1, downstream accepts the result.
REQ-015 SHALL have port flush, input, 1, synchronous abort of the current job.
REQ-016 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, FETCH, ISSUE, WAIT, RESP.
REQ-018 IDLE: req_ready=1; on req_valid latch k_left=max(req_ktiles,1), clear c_sel, go FETCH.
REQ-019 FETCH: tile_ready=1; on tile_valid go ISSUE; otherwise hold indefinitely.
REQ-020 ISSUE: core_load=1 for exactly one cycle, load wait counter with LATENCY-1, go WAIT.
REQ-021 WAIT: decrement counter each cycle; in the cycle the counter reaches 0, w_capture=1 and k_left decrements.
REQ-022 After w_capture: if k_left (post-decrement) > 0, set c_sel=1 and go FETCH; else go RESP.
REQ-023 w_capture SHALL assert exactly LATENCY cycles after the corresponding core_load.
REQ-024 c_sel SHALL stay 0 for the first tile of a job and 1 for every subsequent tile of that job.
REQ-025 RESP: resp_valid=1 held until resp_ready; on handshake go IDLE in the next cycle.
REQ-026 resp_ready high while resp_valid is low SHALL have no effect.
REQ-027 req_ready, tile_ready, core_load, w_capture SHALL be mutually exclusive in any cycle.
REQ-028 flush SHALL have priority over all transitions: next state IDLE, strobes suppressed that cycle, no resp_valid issued for the aborted job.
REQ-029 A req_valid arriving in the same cycle as flush SHALL NOT be accepted.
REQ-030 Minimum single-tile job: req accepted cycle 0, tile in cycle 1, core_load cycle 2, w_capture cycle 2+LATENCY, resp_valid from cycle 3+LATENCY.

Reset
REQ-031 On rst: state IDLE, counters 0, c_sel=0, core_load=0, w_capture=0, tile_ready=0, resp_valid=0, busy=0; req_ready=1 after reset deasserts.
REQ-032 rst asserted mid-job SHALL abandon the job immediately with no further strobes.

Configuration
REQ-033 Macro TCU_SCHED_PERF_CNT_EN defined: add output perf_busy_cycles (32 bits), counting cycles with busy=1, saturating at 0xFFFFFFFF, cleared by rst only.
REQ-034 Macro undefined: port perf_busy_cycles and its counter absent; all other behaviour identical.

Verification
REQ-035 Single tile, LATENCY=11, ktiles=1, tile_valid always high -> core_load cycle 2, w_capture cycle 13, resp_valid cycle 14, c_sel=0 throughout.
REQ-036 ktiles=4, tile_valid always high -> 4 core_load strobes spaced 13 cycles, c_sel 0 then 1,1,1, one resp_valid.
REQ-037 ktiles=0 -> behaves exactly as ktiles=1.
REQ-038 tile_valid low 5 cycles in FETCH, resp_ready low 7 cycles in RESP -> states hold, no extra strobes, resp_valid steady.
REQ-039 flush in WAIT of tile 2 of a 3-tile job -> IDLE next cycle, no w_capture, no resp_valid; next job runs normally.
REQ-040 With TCU_SCHED_PERF_CNT_EN, single-tile job with immediate tile and resp_ready -> perf_busy_cycles = 14 after return to IDLE.
